// File: rtl/prefetch_queue.sv
// prefetch_queue: sequential instruction prefetch with a DEPTH-entry PC/instruction queue,
// branch-redirect flush and in-flight response squashing. Optional macro: PREFETCH_BYPASS_EN.
module prefetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            req_valid_o,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            req_ready_i,
    input  logic            rsp_valid_i,
    input  logic [XLEN-1:0] rsp_inst_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            inst_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_live;
    logic [CNT_W-1:0] r_discard;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  r_rsp_pc;
    entry_t           r_mem [DEPTH];

    logic [OCC_W-1:0] w_occ;
    logic [XLEN-1:0]  w_redirect_pc;
    entry_t           w_head;
    logic             w_accept;
    logic             w_live_rsp;
    logic             w_drop_rsp;
    logic             w_bypass;
    logic             w_pop;
    logic             w_pop_q;
    logic             w_push_q;

    // Queue plus in-flight requests never exceed DEPTH, so a live response always has room.
    assign w_occ         = OCC_W'(r_count) + OCC_W'(r_live);
    assign req_valid_o   = !rst_i && !redirect_i && (r_discard == '0) && (w_occ < OCC_W'(DEPTH));
    assign req_addr_o    = r_fetch_pc;
    assign w_accept      = req_valid_o && req_ready_i;
    assign w_live_rsp    = rsp_valid_i && (r_discard == '0);
    assign w_drop_rsp    = rsp_valid_i && (r_discard != '0);
    assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);
    assign w_head        = r_mem[r_head];

    // Decode-side view: queue head, or the arriving response when bypass is built in.
    always_comb begin
        inst_valid_o = (r_count != '0);
        inst_o       = w_head.inst;
        pc_o         = w_head.pc;
        w_bypass     = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        if (!rst_i && (r_count == '0) && w_live_rsp && !redirect_i) begin
            w_bypass     = 1'b1;
            inst_valid_o = 1'b1;
            inst_o       = rsp_inst_i;
            pc_o         = r_rsp_pc;
        end
`endif
        if (!inst_valid_o) begin
            inst_o = '0;
            pc_o   = '0;
        end
    end

    // A bypassed entry consumed in the same cycle is never written into the queue.
    assign w_pop    = inst_valid_o && inst_ready_i && !redirect_i;
    assign w_pop_q  = w_pop && !w_bypass;
    assign w_push_q = w_live_rsp && !redirect_i && !(w_bypass && inst_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count    <= '0;
            r_live     <= '0;
            r_discard  <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
        end else if (redirect_i) begin
            // Everything still in flight becomes squashed, minus a response landing right now.
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_live     <= '0;
            r_discard  <= r_discard + r_live - CNT_W'(rsp_valid_i);
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (w_live_rsp) begin
                r_rsp_pc <= r_rsp_pc + XLEN'(4);
            end
            if (w_push_q) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop_q) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count   <= r_count + CNT_W'(w_push_q) - CNT_W'(w_pop_q);
            r_live    <= r_live + CNT_W'(w_accept) - CNT_W'(w_live_rsp);
            r_discard <= r_discard - CNT_W'(w_drop_rsp);
        end
    end

    // Storage array; contents are only observed through valid entries, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push_q) begin
            r_mem[r_tail] <= '{pc: r_rsp_pc, inst: rsp_inst_i};
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed bench for prefetch_queue (XLEN=32, DEPTH=4, RESET_PC=0)
// with an in-order 1-cycle memory model whose instruction word is the bitwise inverse of its address.
module tb_prefetch_queue;

`ifdef PREFETCH_BYPASS_EN
    localparam int FIRST_LAT = 1;
`else
    localparam int FIRST_LAT = 2;
`endif

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i;
    logic        rsp_valid_i;
    logic [31:0] rsp_inst_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    prefetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_o   (req_valid_o),
        .req_addr_o    (req_addr_o),
        .req_ready_i   (req_ready_i),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_inst_i    (rsp_inst_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .inst_ready_i  (inst_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          hold_viol;
    bit          rsp_en;
    bit          prev_stall;
    logic [31:0] prev_addr;
    logic [31:0] pend[$];
    logic [31:0] req_q[$];
    int          req_cyc[$];
    logic [31:0] dec_pc[$];
    logic [31:0] dec_inst[$];
    int          dec_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the memory response, log handshakes, advance the memory model.
    task automatic step();
        bit          acc;
        logic [31:0] addr;
        if (rsp_en && pend.size() > 0) begin
            rsp_valid_i = 1'b1;
            rsp_inst_i  = ~pend[0];
        end
        #1;
        acc  = req_valid_o && req_ready_i;
        addr = req_addr_o;
        if (acc) begin
            req_q.push_back(addr);
            req_cyc.push_back(cyc);
        end
        if (prev_stall && req_valid_o && (addr != prev_addr)) hold_viol++;
        prev_stall = req_valid_o && !req_ready_i;
        prev_addr  = addr;
        if (inst_valid_o && inst_ready_i && !redirect_i) begin
            dec_pc.push_back(pc_o);
            dec_inst.push_back(inst_o);
            dec_cyc.push_back(cyc);
        end
        @(posedge clk_i);
        if (rsp_valid_i) void'(pend.pop_front());
        if (acc) pend.push_back(addr);
        @(negedge clk_i);
        rsp_valid_i = 1'b0;
        rsp_inst_i  = '0;
        cyc++;
    endtask

    task automatic clear_logs();
        req_q.delete();
        req_cyc.delete();
        dec_pc.delete();
        dec_inst.delete();
        dec_cyc.delete();
    endtask

    // Memory model drops its pending responses on reset.
    task automatic do_reset();
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        rsp_valid_i   = 1'b0;
        rsp_inst_i    = '0;
        req_ready_i   = 1'b1;
        inst_ready_i  = 1'b1;
        rsp_en        = 1'b1;
        prev_stall    = 1'b0;
        hold_viol     = 0;
        pend.delete();
        clear_logs();
        #1;
        check("rst_req_valid", 32'(req_valid_o), 32'd0);
        check("rst_req_addr", req_addr_o, 32'h0);
        check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        n_tests = 0;
        n_fail  = 0;

        // Streaming: memory and decode always ready.
        do_reset();
        #1;
        check("t1_first_valid", 32'(req_valid_o), 32'd1);
        check("t1_first_addr", req_addr_o, 32'h0);
        for (int i = 0; i < 8; i++) step();
        for (int i = 0; i < 4; i++) begin
            check("t1_req_addr", req_q[i], 32'(4 * i));
            check("t1_req_cyc", 32'(req_cyc[i]), 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            check("t1_dec_pc", dec_pc[i], 32'(4 * i));
            check("t1_dec_inst", dec_inst[i], ~(32'(4 * i)));
            check("t1_dec_cyc", 32'(dec_cyc[i]), 32'(FIRST_LAT + i));
        end

        // Decode stalled: queue fills, issue stops, one pop frees one slot.
        do_reset();
        inst_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #1;
        check("t2_nreq_full", 32'(req_q.size()), 32'd4);
        check("t2_req_blocked", 32'(req_valid_o), 32'd0);
        check("t2_head_valid", 32'(inst_valid_o), 32'd1);
        check("t2_head_pc", pc_o, 32'h0);
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #1;
        check("t2_nreq_after_pop", 32'(req_q.size()), 32'd5);
        check("t2_req5_addr", req_q[4], 32'h10);
        check("t2_req_blocked2", 32'(req_valid_o), 32'd0);
        check("t2_head_pc2", pc_o, 32'h4);
        check("t2_ndec", 32'(dec_pc.size()), 32'd1);

        // Redirect with 2 entries queued and 2 requests in flight.
        do_reset();
        inst_ready_i = 1'b0;
        rsp_en       = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rsp_en = 1'b1;
        step();
        step();
        rsp_en = 1'b0;
        #1;
        check("t3_pre_head_pc", pc_o, 32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        #1;
        check("t3_redir_req_valid", 32'(req_valid_o), 32'd0);
        step();
        redirect_i   = 1'b0;
        inst_ready_i = 1'b1;
        #1;
        check("t3_flush_valid", 32'(inst_valid_o), 32'd0);
        check("t3_flush_pc", pc_o, 32'h0);
        check("t3_discard_block", 32'(req_valid_o), 32'd0);
        clear_logs();
        rsp_en = 1'b1;
        step();
        #1;
        check("t3_still_blocked", 32'(req_valid_o), 32'd0);
        step();
        #1;
        check("t3_no_stale_dec", 32'(dec_pc.size()), 32'd0);
        check("t3_req_valid", 32'(req_valid_o), 32'd1);
        check("t3_req_addr", req_addr_o, 32'h100);
        for (int i = 0; i < 4; i++) step();
        check("t3_first_req", req_q[0], 32'h100);
        check("t3_first_pc", dec_pc[0], 32'h100);
        check("t3_first_inst", dec_inst[0], ~32'h100);

        // Redirect coinciding with a response and a pop.
        do_reset();
        for (int i = 0; i < 3; i++) step();
        n0            = dec_pc.size();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        step();
        redirect_i = 1'b0;
        #1;
        check("t4_flush_valid", 32'(inst_valid_o), 32'd0);
        check("t4_req_valid", 32'(req_valid_o), 32'd1);
        check("t4_req_addr", req_addr_o, 32'h200);
        for (int i = 0; i < 4; i++) step();
        check("t4_pre_last_pc", dec_pc[n0 - 1], 32'(4 * (n0 - 1)));
        check("t4_post_pc0", dec_pc[n0], 32'h200);
        check("t4_post_pc1", dec_pc[n0 + 1], 32'h204);

        // Memory ready toggling every cycle.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req_ready_i = i[0];
            step();
        end
        check("t5_addr_hold", 32'(hold_viol), 32'd0);
        check("t5_nreq", 32'(req_q.size()), 32'd6);
        for (int i = 0; i < 5; i++) check("t5_req_addr", req_q[i], 32'(4 * i));
        check("t5_ndec", 32'(dec_pc.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) check("t5_dec_pc", dec_pc[i], 32'(4 * i));

        // Address wrap; low redirect bits are ignored.
        do_reset();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFB;
        step();
        redirect_i = 1'b0;
        #1;
        check("t6_req_addr", req_addr_o, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) step();
        check("t6_req_wrap", req_q[2], 32'h0);
        check("t6_dec_pc0", dec_pc[0], 32'hFFFF_FFF8);
        check("t6_dec_pc1", dec_pc[1], 32'hFFFF_FFFC);
        check("t6_dec_pc2", dec_pc[2], 32'h0000_0000);
        check("t6_dec_inst2", dec_inst[2], 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
